// File: rtl/uart_core_cfg.sv
// uart_core_cfg: configurable UART on the MMIO slot bus.
//
// Runtime-configurable data width (5..8 bits), 1 or 2 stop bits, even/odd
// parity, sticky error flags. Contains a baud generator, TX and RX FSMs and
// a TX FIFO and an RX FIFO of FIFO_DEPTH entries each.
//
// Optional feature macro: UART_LOOPBACK_EN. When defined, CTRL[21] selects
// internal loopback: RX samples the internal TX line and the tx pin idles high.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cs, read, write     slot select and strobes (strobes qualified by cs)
//   reg_addr[4:0]       word address: 0 CTRL, 1 STATUS, 2 RX_DATA, 3 TX_DATA
//   wr_data[31:0]       write data
//   rd_data[31:0]       combinational read data selected by reg_addr
//   tx                  serial out, idle high
//   rx                  serial in, idle high
module uart_core_cfg #(
  parameter int DVSR_WIDTH = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx,
  input  logic        rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(2 * OVERSAMPLE);
  localparam logic [SW-1:0] S_BIT   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP2 = SW'(2 * OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // Bus decode
  logic ctrl_wr, stat_wr, tx_wr, rx_rd;
  assign ctrl_wr = cs && write && (reg_addr == 5'd0);
  assign stat_wr = cs && write && (reg_addr == 5'd1);
  assign tx_wr   = cs && write && (reg_addr == 5'd3);
  assign rx_rd   = cs && read  && (reg_addr == 5'd2);

  logic unused_wr;
  assign unused_wr = ^wr_data;

  // Configuration and status registers
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [1:0] width_q, width_d, parity_q, parity_d;
  logic stop2_q, stop2_d, loop_en;
  logic [3:0] err_q, err_d;
`ifdef UART_LOOPBACK_EN
  logic loop_q, loop_d;
  assign loop_en = loop_q;
`else
  assign loop_en = 1'b0;
`endif

  // Current-config helpers; FSMs latch these at frame start.
  logic [2:0] cur_last;
  logic [7:0] cur_mask;
  logic cur_pen, cur_odd;
  assign cur_last = 3'd7 - {1'b0, width_q};
  assign cur_mask = 8'hFF >> width_q;
  assign cur_pen  = (parity_q == 2'b01) || (parity_q == 2'b10);
  assign cur_odd  = (parity_q == 2'b10);

  // Baud generator
  logic [DVSR_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic tick;
  assign tick = (baud_cnt_q == dvsr_q);

  // FIFOs
  logic [7:0] tx_mem_q [FIFO_DEPTH];
  logic [7:0] tx_mem_d [FIFO_DEPTH];
  logic [7:0] rx_mem_q [FIFO_DEPTH];
  logic [7:0] rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, tx_push_ok, rx_push, rx_push_ok, rx_pop_ok;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  // A push into a full FIFO still succeeds when a pop frees a slot that cycle.
  assign tx_push_ok = tx_wr && (!tx_full || tx_pop);
  assign rx_pop_ok  = rx_rd && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop_ok);

  // TX FSM state
  state_e tx_state_q, tx_state_d;
  logic [SW-1:0] tx_s_q, tx_s_d;
  logic [2:0] tx_n_q, tx_n_d, tx_last_q, tx_last_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d, tx_line_q, tx_line_d;

  // RX FSM state
  state_e rx_state_q, rx_state_d;
  logic [SW-1:0] rx_s_q, rx_s_d;
  logic [2:0] rx_n_q, rx_n_d, rx_last_q, rx_last_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic rx_par_q, rx_par_d, rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_src, rx_fall;
  logic rx_frame_set, rx_par_set;
  assign rx_src  = loop_en ? tx_line_q : rx_sync_q;
  assign rx_fall = rx_prev_q && !rx_src;

  assign tx = loop_en ? 1'b1 : tx_line_q;

  // Registers, baud counter, FIFOs, error flags
  always_comb begin
    dvsr_d   = dvsr_q;
    width_d  = width_q;
    stop2_d  = stop2_q;
    parity_d = parity_q;
`ifdef UART_LOOPBACK_EN
    loop_d   = loop_q;
`endif
    if (ctrl_wr) begin
      dvsr_d   = wr_data[DVSR_WIDTH-1:0];
      width_d  = wr_data[17:16];
      stop2_d  = wr_data[18];
      parity_d = wr_data[20:19];
`ifdef UART_LOOPBACK_EN
      loop_d   = wr_data[21];
`endif
    end

    baud_cnt_d = baud_cnt_q + DVSR_WIDTH'(1);
    if (ctrl_wr || tick) baud_cnt_d = '0;

    tx_mem_d = tx_mem_q;
    if (tx_push_ok) tx_mem_d[tx_wr_q] = wr_data[7:0];
    tx_wr_d  = tx_wr_q + AW'(tx_push_ok);
    tx_rd_d  = tx_rd_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop);

    rx_mem_d = rx_mem_q;
    if (rx_push_ok) rx_mem_d[rx_wr_q] = rx_byte_q;
    rx_wr_d  = rx_wr_q + AW'(rx_push_ok);
    rx_rd_d  = rx_rd_q + AW'(rx_pop_ok);
    rx_cnt_d = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop_ok);

    // Clear first, then OR in hardware events so a same-cycle set wins.
    err_d = err_q;
    if (stat_wr) err_d = err_q & ~wr_data[3:0];
    err_d = err_d | {tx_wr && !tx_push_ok, rx_push && !rx_push_ok, rx_frame_set, rx_par_set};
  end

  // TX FSM next state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_last_d  = tx_last_q;
    tx_pen_d   = tx_pen_q;
    tx_stop2_d = tx_stop2_q;
    tx_line_d  = 1'b1;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = tx_mem_q[tx_rd_q];
        tx_par_d   = (^(tx_mem_q[tx_rd_q] & cur_mask)) ^ cur_odd;
        tx_last_d  = cur_last;
        tx_pen_d   = cur_pen;
        tx_stop2_d = stop2_q;
        tx_s_d     = '0;
        tx_state_d = S_START;
      end
      S_START: begin
        tx_line_d = 1'b0;
        if (tick) begin
          if (tx_s_q == S_BIT) begin
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_state_d = S_DATA;
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      S_DATA: begin
        tx_line_d = tx_sh_q[0];
        if (tick) begin
          if (tx_s_q == S_BIT) begin
            tx_s_d  = '0;
            tx_sh_d = tx_sh_q >> 1;
            if (tx_n_q == tx_last_q) tx_state_d = tx_pen_q ? S_PARITY : S_STOP;
            else tx_n_d = tx_n_q + 3'd1;
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      S_PARITY: begin
        tx_line_d = tx_par_q;
        if (tick) begin
          if (tx_s_q == S_BIT) begin
            tx_s_d     = '0;
            tx_state_d = S_STOP;
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tx_s_q == (tx_stop2_q ? S_STOP2 : S_BIT)) tx_state_d = S_IDLE;
          else tx_s_d = tx_s_q + SW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // RX FSM next state
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_s_d       = rx_s_q;
    rx_n_d       = rx_n_q;
    rx_byte_d    = rx_byte_q;
    rx_par_d     = rx_par_q;
    rx_last_d    = rx_last_q;
    rx_pen_d     = rx_pen_q;
    rx_odd_d     = rx_odd_q;
    rx_push      = 1'b0;
    rx_frame_set = 1'b0;
    rx_par_set   = 1'b0;
    case (rx_state_q)
      S_IDLE: if (rx_fall) begin
        rx_s_d     = '0;
        rx_byte_d  = '0;
        rx_last_d  = cur_last;
        rx_pen_d   = cur_pen;
        rx_odd_d   = cur_odd;
        rx_state_d = S_START;
      end
      S_START: if (tick) begin
        // Mid-start re-check rejects glitches shorter than half a bit.
        if (rx_s_q == S_HALF) begin
          rx_s_d     = '0;
          rx_n_d     = '0;
          rx_state_d = rx_src ? S_IDLE : S_DATA;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      S_DATA: if (tick) begin
        if (rx_s_q == S_BIT) begin
          rx_s_d            = '0;
          rx_byte_d[rx_n_q] = rx_src;
          if (rx_n_q == rx_last_q) rx_state_d = rx_pen_q ? S_PARITY : S_STOP;
          else rx_n_d = rx_n_q + 3'd1;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      S_PARITY: if (tick) begin
        if (rx_s_q == S_BIT) begin
          rx_s_d     = '0;
          rx_par_d   = rx_src;
          rx_state_d = S_STOP;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      S_STOP: if (tick) begin
        if (rx_s_q == S_BIT) begin
          rx_push      = 1'b1;
          rx_frame_set = !rx_src;
          rx_par_set   = rx_pen_q && (rx_par_q != ((^rx_byte_q) ^ rx_odd_q));
          rx_state_d   = S_IDLE;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr_q <= '0; width_q <= '0; stop2_q <= 1'b0; parity_q <= '0; err_q <= '0;
`ifdef UART_LOOPBACK_EN
      loop_q <= 1'b0;
`endif
      baud_cnt_q <= '0;
      tx_mem_q <= '{default: '0}; rx_mem_q <= '{default: '0};
      tx_wr_q <= '0; tx_rd_q <= '0; tx_cnt_q <= '0;
      rx_wr_q <= '0; rx_rd_q <= '0; rx_cnt_q <= '0;
      tx_state_q <= S_IDLE; tx_s_q <= '0; tx_n_q <= '0; tx_sh_q <= '0; tx_par_q <= 1'b0;
      tx_last_q <= '0; tx_pen_q <= 1'b0; tx_stop2_q <= 1'b0; tx_line_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_s_q <= '0; rx_n_q <= '0; rx_byte_q <= '0; rx_par_q <= 1'b0;
      rx_last_q <= '0; rx_pen_q <= 1'b0; rx_odd_q <= 1'b0;
      rx_meta_q <= 1'b1; rx_sync_q <= 1'b1; rx_prev_q <= 1'b1;
    end else begin
      dvsr_q <= dvsr_d; width_q <= width_d; stop2_q <= stop2_d; parity_q <= parity_d; err_q <= err_d;
`ifdef UART_LOOPBACK_EN
      loop_q <= loop_d;
`endif
      baud_cnt_q <= baud_cnt_d;
      tx_mem_q <= tx_mem_d; rx_mem_q <= rx_mem_d;
      tx_wr_q <= tx_wr_d; tx_rd_q <= tx_rd_d; tx_cnt_q <= tx_cnt_d;
      rx_wr_q <= rx_wr_d; rx_rd_q <= rx_rd_d; rx_cnt_q <= rx_cnt_d;
      tx_state_q <= tx_state_d; tx_s_q <= tx_s_d; tx_n_q <= tx_n_d; tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d;
      tx_last_q <= tx_last_d; tx_pen_q <= tx_pen_d; tx_stop2_q <= tx_stop2_d; tx_line_q <= tx_line_d;
      rx_state_q <= rx_state_d; rx_s_q <= rx_s_d; rx_n_q <= rx_n_d; rx_byte_q <= rx_byte_d; rx_par_q <= rx_par_d;
      rx_last_q <= rx_last_d; rx_pen_q <= rx_pen_d; rx_odd_q <= rx_odd_d;
      rx_meta_q <= rx; rx_sync_q <= rx_meta_q; rx_prev_q <= rx_src;
    end
  end

  // Read mux
  always_comb begin
    rd_data = '0;
    case (reg_addr)
      5'd0: begin
        rd_data[DVSR_WIDTH-1:0] = dvsr_q;
        rd_data[17:16] = width_q;
        rd_data[18]    = stop2_q;
        rd_data[20:19] = parity_q;
        rd_data[21]    = loop_en;
      end
      5'd1: begin
        rd_data[3:0] = err_q;
        rd_data[8]   = rx_empty;
        rd_data[9]   = rx_full;
        rd_data[10]  = tx_empty;
        rd_data[11]  = tx_full;
      end
      5'd2: begin
        rd_data[7:0] = rx_empty ? 8'h00 : (rx_mem_q[rx_rd_q] & cur_mask);
        rd_data[8]   = rx_empty;
      end
      default: rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_core_cfg.sv
module tb_uart_core_cfg;
  localparam int DVSR = 7;
  localparam int BITP = (DVSR + 1) * 16;
`ifdef UART_LOOPBACK_EN
  localparam logic [31:0] CTRL_ALL = 32'h003F07FF;
`else
  localparam logic [31:0] CTRL_ALL = 32'h001F07FF;
`endif

  logic clk = 1'b0;
  logic reset, cs, read, write, tx, rx;
  logic [4:0] reg_addr;
  logic [31:0] wr_data, rd_data;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          do_wr;
    logic [4:0]  wr_addr;
    logic [31:0] wdata;
    logic [4:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_core_cfg #(.DVSR_WIDTH(11), .FIFO_DEPTH(2), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data), .tx(tx), .rx(rx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; read = 1'b0; reg_addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; write = 1'b0; reg_addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(5'd1, v);
    check(name, v, exp);
  endtask

  // Scoreboard: pops RX_DATA and compares with the oldest expected byte.
  task automatic check_rx(input string name);
    logic [31:0] v;
    bus_read(5'd2, v);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got 0x%08h, expected nothing queued", name, v);
    end else check(name, v, exp_q.pop_front());
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                            input logic stop_val, input int nstop);
    logic p;
    p = 1'b0;
    @(negedge clk); rx = 1'b0;
    repeat (BITP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i]; p ^= d[i];
      repeat (BITP) @(negedge clk);
    end
    if (par != 0) begin
      rx = (par == 2) ? ~p : p;
      repeat (BITP) @(negedge clk);
    end
    rx = stop_val;
    repeat (BITP) @(negedge clk);
    rx = 1'b1;
    repeat (BITP * nstop) @(negedge clk);
  endtask

  task automatic wait_tx_fall(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 * BITP; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: got no start bit, expected one within %0d cycles", name, 20 * BITP);
    end
  endtask

  // Called right after a detected start edge; samples each bit mid-period.
  task automatic sample_tx_frame(input string name, input logic [7:0] d, input int nbits,
                                 input int par, input int nstop);
    logic p;
    p = (par == 2);
    repeat (BITP / 2) @(negedge clk);
    check({name, " start"}, {31'b0, tx}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      repeat (BITP) @(negedge clk);
      check($sformatf("%s bit%0d", name, i), {31'b0, tx}, {31'b0, d[i]});
      p ^= d[i];
    end
    if (par != 0) begin
      repeat (BITP) @(negedge clk);
      check({name, " parity"}, {31'b0, tx}, {31'b0, p});
    end
    for (int i = 0; i < nstop; i++) begin
      repeat (BITP) @(negedge clk);
      check($sformatf("%s stop%0d", name, i), {31'b0, tx}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] v;
    int t0, dt, lowcnt;
    cs = 0; read = 0; write = 0; reg_addr = '0; wr_data = '0; rx = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("tx in reset", {31'b0, tx}, 32'd1);
    reset = 1'b0;

    // Register-level vectors
    vecs[0] = '{1'b0, 5'd0, 32'h0,        5'd0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd1, 32'h0000_0500};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd2, 32'h0000_0100};
    vecs[3] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, CTRL_ALL};
    vecs[4] = '{1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd0, CTRL_ALL};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd3, 32'h0};
    vecs[7] = '{1'b1, 5'd1, 32'h0000_000F, 5'd1, 32'h0000_0500};
    vecs[8] = '{1'b1, 5'd0, 32'h0001_2345, 5'd0, 32'h0001_0345};
    vecs[9] = '{1'b1, 5'd0, 32'h0,        5'd0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wdata);
      bus_read(vecs[i].rd_addr, v);
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end
    check("tx idle", {31'b0, tx}, 32'd1);

    // TX 8N1, 0xAC
    bus_write(5'd0, DVSR);
    bus_write(5'd3, 32'hAC);
    wait_tx_fall("tx 0xAC");
    sample_tx_frame("tx 0xAC", 8'hAC, 8, 0, 1);
    repeat (BITP) @(negedge clk);
    check_status("status after tx", 32'h0000_0500);

    // TX 7 bits, odd parity, 2 stop, two back-to-back frames
    bus_write(5'd0, DVSR | (1 << 16) | (1 << 18) | (2 << 19));
    bus_write(5'd3, 32'hC1);
    bus_write(5'd3, 32'h2A);
    wait_tx_fall("tx 7O2 a");
    t0 = cyc;
    sample_tx_frame("tx 7O2 a", 8'hC1, 7, 2, 2);
    wait_tx_fall("tx 7O2 b");
    dt = cyc - t0;
    checks++;
    if (dt < 11 * BITP - 9 || dt > 11 * BITP + 2) begin
      errors++;
      $display("FAIL tx frame spacing: got %0d cycles, expected about %0d", dt, 11 * BITP);
    end
    sample_tx_frame("tx 7O2 b", 8'h2A, 7, 2, 2);

    // Config latched per frame: width change mid-frame does not affect it
    repeat (BITP) @(negedge clk);
    bus_write(5'd0, DVSR);
    bus_write(5'd3, 32'h0F);
    wait_tx_fall("tx latch");
    bus_write(5'd0, DVSR | (3 << 16));
    sample_tx_frame("tx latch", 8'h0F, 8, 0, 1);

    // TX FIFO overflow drops the byte and sets tx_drop
    repeat (BITP) @(negedge clk);
    bus_write(5'd0, DVSR);
    for (int i = 1; i <= 4; i++) bus_write(5'd3, i);
    check_status("status tx drop", 32'h0000_0908);
    bus_write(5'd1, 32'h8);
    check_status("status tx drop clr", 32'h0000_0900);
    repeat (31 * BITP) @(negedge clk);
    check_status("status tx drained", 32'h0000_0500);

`ifdef UART_LOOPBACK_EN
    bus_write(5'd0, DVSR | (1 << 21));
    bus_write(5'd3, 32'h5A);
    exp_q.push_back(32'h5A);
    lowcnt = 0;
    for (int i = 0; i < 12 * BITP; i++) begin
      @(negedge clk);
      if (tx == 1'b0) lowcnt++;
    end
    check("loopback tx low cycles", lowcnt, 0);
    check_rx("loopback rx");
`else
    lowcnt = 0;
`endif

    // RX 7 bits, even parity, 2 stop
    bus_write(5'd0, DVSR | (1 << 16) | (1 << 18) | (1 << 19));
    send_frame(8'h41, 7, 1, 1'b1, 2);
    exp_q.push_back(32'h41);
    check_status("status rx 7E2", 32'h0000_0400);
    check_rx("rx 7E2");

    // RX odd parity configured, even-parity frame arrives
    bus_write(5'd0, DVSR | (2 << 19));
    send_frame(8'h67, 8, 1, 1'b1, 1);
    exp_q.push_back(32'h67);
    check_status("status parity err", 32'h0000_0401);
    check_rx("rx parity err data");
    bus_write(5'd1, 32'h1);
    check_status("status parity clr", 32'h0000_0500);

    // Frame error, then a glitch shorter than half a bit
    bus_write(5'd0, DVSR);
    send_frame(8'h33, 8, 0, 1'b0, 1);
    exp_q.push_back(32'h33);
    check_status("status frame err", 32'h0000_0402);
    check_rx("rx frame err data");
    bus_write(5'd1, 32'h2);
    @(negedge clk); rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BITP) @(negedge clk);
    check_status("status after glitch", 32'h0000_0500);

    // RX overrun with two-entry FIFO
    send_frame(8'h79, 8, 0, 1'b1, 1);
    send_frame(8'h12, 8, 0, 1'b1, 1);
    send_frame(8'h6B, 8, 0, 1'b1, 1);
    exp_q.push_back(32'h79);
    exp_q.push_back(32'h12);
    exp_q.push_back(32'h100);
    check_status("status overrun", 32'h0000_0604);
    check_rx("rx fifo 0");
    check_rx("rx fifo 1");
    check_rx("rx fifo empty");
    check_status("status overrun sticky", 32'h0000_0504);
    bus_write(5'd1, 32'h4);
    check_status("status overrun clr", 32'h0000_0500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
